btn_conditioner: RTL and testbench
==================================

Name: btn_conditioner

Overview:
- Conditions one raw push-button into a clean single-cycle increment pulse for the time-setting inputs (inc_hrs / inc_mins) of the binary clock core.
- Stages: 2-FF synchroniser, then debounce FSM, then edge pulse, then optional hold-to-auto-repeat.
- Instantiated once per button at top level. Drives the clock core directly in the clk_100MHz domain.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable synced samples required to accept a press or release (10 ms at 100 MHz); must be >= 1.
- HOLD_CYCLES, 50_000_000, cycles from the first pulse to the first auto-repeat pulse (500 ms); must be >= 1.
- REPEAT_CYCLES, 20_000_000, cycles between successive auto-repeat pulses (200 ms); must be >= 1.

Ports:
- clk_100MHz  in   1  system clock, 100 MHz, sole clock.
- reset       in   1  synchronous, active-low reset (0 = reset).
- btn_in      in   1  raw asynchronous button level, 1 = pressed.
- btn_level   out  1  debounced, registered button level.
- btn_pulse   out  1  one-cycle increment strobe; connects to inc_hrs or inc_mins.
- repeat_act  out  1  high while auto-repeat is running.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state = IDLE, both synchroniser FFs = 0, all counters = 0.
  - btn_level = 0, btn_pulse = 0, repeat_act = 0.
  - Reset mid-operation aborts immediately: no pulse is emitted in or after the reset cycle.
- Synchroniser: s = btn_in delayed 2 cycles. All FSM decisions use s only.
- States: IDLE, PRESS_WAIT, HELD, REPEAT, RELEASE_WAIT.
- IDLE:
  - s=1: go to PRESS_WAIT, cnt = 1.
- PRESS_WAIT:
  - s=0: back to IDLE, cnt = 0 (glitch rejected).
  - s=1 and cnt = DEBOUNCE_CYCLES: go to HELD, btn_level = 1, btn_pulse = 1 for exactly one cycle, hold counter cleared.
  - Otherwise cnt increments.
- Press latency: btn_in high and stable before edge 0 gives btn_pulse high in the cycle after edge DEBOUNCE_CYCLES+2.
- HELD:
  - Hold counter increments each cycle.
  - At HOLD_CYCLES (macro on): go to REPEAT, btn_pulse = 1, repeat_act = 1, repeat counter cleared.
  - s=0: go to RELEASE_WAIT; hold counter frozen.
- REPEAT:
  - Repeat counter increments.
  - At REPEAT_CYCLES: btn_pulse = 1 and counter restarts.
  - s=0: go to RELEASE_WAIT; counter frozen.
- RELEASE_WAIT:
  - s=1 before DEBOUNCE_CYCLES consecutive zeros: return to HELD or REPEAT (per repeat_act). No pulse; frozen counter resumes, so timing shifts by the glitch length.
  - DEBOUNCE_CYCLES consecutive zeros: go to IDLE, btn_level = 0, repeat_act = 0.
- btn_pulse is never high two consecutive cycles.
- btn_pulse is never high in IDLE, PRESS_WAIT or RELEASE_WAIT.
- Counter widths: $clog2(param+1) each. Counters saturate, never wrap.
- Button held through reset: after reset rises, the press is re-detected from IDLE and yields a pulse DEBOUNCE_CYCLES+2 cycles later.

Optional Feature:
- Macro BTN_AUTO_REPEAT_EN.
- Defined: HELD to REPEAT transition and periodic pulses as above.
- Undefined:
  - REPEAT state and repeat counter are not built; repeat_act is tied 0.
  - HELD stays in HELD until release, so exactly one pulse per accepted press.
  - HOLD_CYCLES and REPEAT_CYCLES are ignored.

Decomposition:
- Package btn_pkg:
  - state enum typedef.
  - Default timing constants for 100 MHz (10 ms, 500 ms, 200 ms in cycles).
  - Simulation-scale constants (4/20/8).
- Sub-module sync_2ff: 2-flop synchroniser, reset-to-0, same clock/reset convention. The rest of the logic stays in btn_conditioner.

Test Plan (DEBOUNCE=4, HOLD=20, REPEAT=8; times are cycles after btn_in rise edge 0):
- Clean press held 15 cycles then released, macro off -> btn_pulse high only at t=6; btn_level 1 from t=6; btn_level 0 at release+6; no further pulses.
- btn_in high for 3 cycles then low -> no pulse; btn_level stays 0; FSM back in IDLE by t=6.
- Hold 60 cycles, macro on -> pulses at t=6, 26, 34, 42, 50, 58; repeat_act high from t=26 until release+6.
- Hold 60 cycles, macro off -> single pulse at t=6; repeat_act always 0.
- During HELD at t=10, btn_in low for 2 cycles -> btn_level stays 1, no extra pulse; with macro on, first repeat at t=28 (shifted by 2).
- reset=0 for one cycle at t=4 while btn_in stays high -> no pulse at t=6; all outputs 0 in the cycle after reset; pulse 6 cycles after reset returns to 1.

Source files
------------

// File: rtl/btn_pkg.sv
// State encoding and timing constants shared by the button conditioner.
// Build option: BTN_AUTO_REPEAT_EN adds the REPEAT state for hold-to-repeat.
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESS_WAIT   = 3'd1,
        HELD         = 3'd2,
        RELEASE_WAIT = 3'd3
`ifdef BTN_AUTO_REPEAT_EN
        ,
        REPEAT       = 3'd4
`endif
    } btn_state_t;

    // 10 ms / 500 ms / 200 ms at 100 MHz
    localparam int DEBOUNCE_CYCLES_100MHZ = 1_000_000;
    localparam int HOLD_CYCLES_100MHZ     = 50_000_000;
    localparam int REPEAT_CYCLES_100MHZ   = 20_000_000;

    localparam int DEBOUNCE_CYCLES_SIM = 4;
    localparam int HOLD_CYCLES_SIM     = 20;
    localparam int REPEAT_CYCLES_SIM   = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser bringing the raw button level into the clk_100MHz domain.
// Build option: none.
module sync_2ff (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // NOTE: sequential state uses non-blocking assignment so both flops sample the old values together.
    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/btn_conditioner.sv
// Raw push-button -> synchronised, debounced level plus a one-cycle increment pulse.
// Build option: BTN_AUTO_REPEAT_EN enables hold-to-auto-repeat pulses and repeat_act.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_100MHZ,
    parameter int HOLD_CYCLES     = HOLD_CYCLES_100MHZ,
    parameter int REPEAT_CYCLES   = REPEAT_CYCLES_100MHZ
) (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_pulse,
    output logic repeat_act
);

    localparam int              DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_ONE = DB_W'(1);

    if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("btn_conditioner: timing parameters must be >= 1");
    end

    btn_state_t      r_state, w_state_nxt;
    logic [DB_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic            r_level, w_level_nxt;
    logic            r_pulse, w_pulse_nxt;
    logic            w_sync;

`ifdef BTN_AUTO_REPEAT_EN
    localparam int                HOLD_W   = $clog2(HOLD_CYCLES + 1);
    localparam int                REP_W    = $clog2(REPEAT_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic [REP_W-1:0]  REP_MAX  = REP_W'(REPEAT_CYCLES);
    localparam logic [REP_W-1:0]  REP_ONE  = REP_W'(1);

    logic [HOLD_W-1:0] r_hold, w_hold_nxt, w_hold_inc;
    logic [REP_W-1:0]  r_rep, w_rep_nxt, w_rep_inc;
    logic              r_rep_act, w_rep_act_nxt;
    logic              w_held_run, w_rep_run;
`endif

    sync_2ff u_sync (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .i_d        (btn_in),
        .o_q        (w_sync)
    );

    assign w_cnt_inc = (r_cnt == DB_MAX) ? r_cnt : r_cnt + DB_ONE;

`ifdef BTN_AUTO_REPEAT_EN
    assign w_hold_inc = (r_hold == HOLD_MAX) ? r_hold : r_hold + HOLD_ONE;
    assign w_rep_inc  = (r_rep == REP_MAX) ? r_rep : r_rep + REP_ONE;
    // A glitch that ends inside RELEASE_WAIT resumes the frozen timer on that same cycle.
    assign w_held_run = w_sync && (r_state == HELD || (r_state == RELEASE_WAIT && !r_rep_act));
    assign w_rep_run  = w_sync && (r_state == REPEAT || (r_state == RELEASE_WAIT && r_rep_act));
`endif

    always_comb begin
        // NOTE: every combinational output is defaulted first so no path can infer a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_pulse_nxt = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
        w_hold_nxt    = r_hold;
        w_rep_nxt     = r_rep;
        w_rep_act_nxt = r_rep_act;
`endif

        unique case (r_state)
            IDLE: begin
                if (w_sync) begin
                    w_state_nxt = PRESS_WAIT;
                    w_cnt_nxt   = DB_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!w_sync) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DB_MAX) begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b1;
                    w_pulse_nxt = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
                    w_hold_nxt  = '0;
`endif
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            RELEASE_WAIT: begin
                if (w_sync) begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DB_MAX) begin
                    w_state_nxt   = IDLE;
                    w_cnt_nxt     = '0;
                    w_level_nxt   = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
                    w_rep_act_nxt = 1'b0;
`endif
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                if (!w_sync) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_cnt_nxt   = DB_ONE;
                end
            end
        endcase

`ifdef BTN_AUTO_REPEAT_EN
        if (w_held_run) begin
            w_hold_nxt = w_hold_inc;
            if (w_hold_inc == HOLD_MAX) begin
                w_state_nxt   = REPEAT;
                w_pulse_nxt   = 1'b1;
                w_rep_act_nxt = 1'b1;
                w_rep_nxt     = '0;
            end
        end
        if (w_rep_run) begin
            w_state_nxt = REPEAT;
            if (w_rep_inc == REP_MAX) begin
                w_pulse_nxt = 1'b1;
                w_rep_nxt   = '0;
            end else begin
                w_rep_nxt = w_rep_inc;
            end
        end
`endif
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_pulse <= w_pulse_nxt;
        end
    end

`ifdef BTN_AUTO_REPEAT_EN
    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            r_hold    <= '0;
            r_rep     <= '0;
            r_rep_act <= 1'b0;
        end else begin
            r_hold    <= w_hold_nxt;
            r_rep     <= w_rep_nxt;
            r_rep_act <= w_rep_act_nxt;
        end
    end

    assign repeat_act = r_rep_act;
`else
    assign repeat_act = 1'b0;
`endif

    assign btn_level = r_level;
    assign btn_pulse = r_pulse;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner at simulation scale (debounce 4, hold 20, repeat 8).
// Expectations follow BTN_AUTO_REPEAT_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_btn_conditioner;
    import btn_pkg::*;

    logic clk_100MHz = 1'b0;
    logic reset      = 1'b0;
    logic btn_in     = 1'b0;
    logic btn_level;
    logic btn_pulse;
    logic repeat_act;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_pulses[$];

    btn_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES_SIM),
        .HOLD_CYCLES     (HOLD_CYCLES_SIM),
        .REPEAT_CYCLES   (REPEAT_CYCLES_SIM)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_pulse  (btn_pulse),
        .repeat_act (repeat_act)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic check(input string tag, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // t counts edges after btn_in rises; outputs are sampled in the cycle following edge t.
    // A window of -1/-1 means "never"; exp_pulses lists the cycles where btn_pulse is high.
    task automatic run_case(input string name, input int hold_len, input int glitch_at,
                            input int glitch_len, input int reset_at, input int total,
                            input int lvl_on, input int lvl_off, input int rep_on, input int rep_off);
        logic exp_p;
        btn_in = 1'b0;
        reset  = 1'b0;
        repeat (3) @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        check($sformatf("%s reset level", name), btn_level, 1'b0);
        check($sformatf("%s reset pulse", name), btn_pulse, 1'b0);
        check($sformatf("%s reset repeat", name), repeat_act, 1'b0);
        for (int t = 0; t < total; t++) begin
            btn_in = (t < hold_len) && !(t >= glitch_at && t < glitch_at + glitch_len);
            reset  = (t == reset_at) ? 1'b0 : 1'b1;
            @(posedge clk_100MHz);
            @(negedge clk_100MHz);
            exp_p = 1'b0;
            foreach (exp_pulses[i]) if (exp_pulses[i] == t) exp_p = 1'b1;
            check($sformatf("%s pulse t=%0d", name, t), btn_pulse, exp_p);
            check($sformatf("%s level t=%0d", name, t), btn_level, (t >= lvl_on && t < lvl_off));
            check($sformatf("%s repeat t=%0d", name, t), repeat_act, (t >= rep_on && t < rep_off));
        end
    endtask

    initial begin
        exp_pulses = '{6};
        run_case("clean15", 15, -1, 0, -1, 26, 6, 21, -1, -1);

        exp_pulses.delete();
        run_case("short3", 3, -1, 0, -1, 10, -1, -1, -1, -1);

`ifdef BTN_AUTO_REPEAT_EN
        exp_pulses = '{6, 26, 34, 42, 50, 58};
        run_case("hold60", 60, -1, 0, -1, 72, 6, 66, 26, 66);

        exp_pulses = '{6, 28, 36};
        run_case("glitch_held", 40, 10, 2, -1, 50, 6, 46, 28, 46);
`else
        exp_pulses = '{6};
        run_case("hold60", 60, -1, 0, -1, 72, 6, 66, -1, -1);

        exp_pulses = '{6};
        run_case("glitch_held", 40, 10, 2, -1, 50, 6, 46, -1, -1);
`endif

        exp_pulses = '{11};
        run_case("reset_mid", 20, -1, 0, 4, 30, 11, 26, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
